// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline-stage buffer.
// State encoding, EX/MEM control-bit indices and per-stage widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam int CTRL_ZF       = 0;
  localparam int CTRL_BRANCH   = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 4;

  localparam int IF_ID_DATA_W  = 64;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_DATA_W  = 133;
  localparam int ID_EX_CTRL_W  = 9;
  localparam int EX_MEM_DATA_W = 101;
  localparam int EX_MEM_CTRL_W = 5;
  localparam int MEM_WB_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 2;

endpackage

// File: rtl/pipe_sat_counter.sv
// Width-parametrised saturating up-counter.
// Holds at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count up on inc, stop at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Generic pipeline-stage register with valid/ready and a 2-entry skid.
// Optional stall counter enabled by PIPE_STALL_CNT_EN.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int CTRL_W = EX_MEM_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
`ifdef PIPE_STALL_CNT_EN
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [CNT_W-1:0]  o_stall_cnt
`else
  output logic [CTRL_W-1:0] o_ctrl
`endif
);

  state_t            state;
  logic [DATA_W-1:0] main_d;
  logic [CTRL_W-1:0] main_c;
  logic [DATA_W-1:0] skid_d;
  logic [CTRL_W-1:0] skid_c;

  // handshake outputs decode straight from the state flop
  assign o_valid = (state != EMPTY);
  assign o_ready = (state != SKID);
  assign o_data  = main_d;
  assign o_ctrl  = main_c;

  // state and storage update; flush beats any capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_d <= '0;
      main_c <= '0;
      skid_d <= '0;
      skid_c <= '0;
    end else if (i_flush) begin
      state  <= EMPTY;
      main_c <= '0;
      skid_c <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (i_valid) begin
            main_d <= i_data;
            main_c <= i_ctrl;
            state  <= FULL;
          end
        end
        FULL: begin
          if (i_ready) begin
            if (i_valid) begin
              main_d <= i_data;
              main_c <= i_ctrl;
            end else begin
              main_c <= '0;
              state  <= EMPTY;
            end
          end else if (i_valid) begin
            skid_d <= i_data;
            skid_c <= i_ctrl;
            state  <= SKID;
          end
        end
        SKID: begin
          if (i_ready) begin
            main_d <= skid_d;
            main_c <= skid_c;
            state  <= FULL;
          end
        end
        default: begin
          main_c <= '0;
          state  <= EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic stall;

  // a stall is a held entry the downstream refuses
  assign stall = o_valid & ~i_ready;

  pipe_sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall),
    .cnt  (o_stall_cnt)
  );
`else
  // counter width has no hardware in this build
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Randomised bench for pipe_stage_buffer against a queue model.
// Define PIPE_STALL_CNT_EN to also check the stall counter.
module tb_pipe_stage_buffer;
  import pipe_pkg::*;

  localparam int DATA_W = 101;
  localparam int CTRL_W = 5;
`ifdef PIPE_STALL_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic              clk;
  logic              rst_n;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [CTRL_W-1:0] i_ctrl;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [CTRL_W-1:0] o_ctrl;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0]  o_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] qd[$];
  logic [CTRL_W-1:0] qc[$];
  int exp_cnt = 0;

  pipe_stage_buffer #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .i_ctrl     (i_ctrl),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
`ifdef PIPE_STALL_CNT_EN
    .o_ctrl     (o_ctrl),
    .o_stall_cnt(o_stall_cnt)
`else
    .o_ctrl     (o_ctrl)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: up to two entries in order, front one on the outputs
  task automatic model_step();
    int max_cnt;
    bit rdy;
    bit acc;
    bit con;
    max_cnt = (1 << CNT_W) - 1;
    rdy = (qd.size() < 2);
    acc = i_valid && rdy;
    con = (qd.size() > 0) && i_ready;
    if (qd.size() > 0 && !i_ready && exp_cnt < max_cnt)
      exp_cnt++;
    if (i_flush) begin
      qd.delete();
      qc.delete();
    end else begin
      if (con) begin
        void'(qd.pop_front());
        void'(qc.pop_front());
      end
      if (acc) begin
        qd.push_back(i_data);
        qc.push_back(i_ctrl);
      end
    end
  endtask

  task automatic compare();
    chk("valid", 128'(o_valid), 128'(qd.size() > 0));
    chk("ready", 128'(o_ready), 128'(qd.size() < 2));
    if (qd.size() > 0) begin
      chk("data", 128'(o_data), 128'(qd[0]));
      chk("ctrl", 128'(o_ctrl), 128'(qc[0]));
    end else begin
      chk("ctrl_bubble", 128'(o_ctrl), 128'(0));
    end
`ifdef PIPE_STALL_CNT_EN
    chk("stall_cnt", 128'(o_stall_cnt), 128'(exp_cnt));
`endif
  endtask

  task automatic cyc(input logic v,
                     input logic [DATA_W-1:0] d,
                     input logic [CTRL_W-1:0] c,
                     input logic r,
                     input logic f);
    i_valid = v;
    i_data  = d;
    i_ctrl  = c;
    i_ready = r;
    i_flush = f;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 128'(o_valid), 128'(0));
    chk({tag, "_ready"}, 128'(o_ready), 128'(1));
    chk({tag, "_data"}, 128'(o_data), 128'(0));
    chk({tag, "_ctrl"}, 128'(o_ctrl), 128'(0));
`ifdef PIPE_STALL_CNT_EN
    chk({tag, "_cnt"}, 128'(o_stall_cnt), 128'(0));
`endif
  endtask

  initial begin
    logic [CTRL_W-1:0] all1;
    logic [DATA_W-1:0] rd;
    all1 = '1;
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    i_ctrl = '0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;

    // streaming
    cyc(1, 'h10, 5'h01, 1, 0);
    chk("stream0", 128'(o_data), 128'h10);
    cyc(1, 'h20, 5'h02, 1, 0);
    chk("stream1", 128'(o_data), 128'h20);
    cyc(1, 'h30, 5'h03, 1, 0);
    chk("stream2", 128'(o_data), 128'h30);
    chk("stream_rdy", 128'(o_ready), 128'(1));
    cyc(0, '0, '0, 1, 0);

    // stall into skid, then release
    cyc(1, 'hAA, 5'h04, 1, 0);
    cyc(1, 'hBB, 5'h08, 0, 0);
    chk("skid_rdy", 128'(o_ready), 128'(0));
    chk("skid_hold", 128'(o_data), 128'hAA);
    cyc(0, '0, '0, 1, 0);
    chk("skid_next", 128'(o_data), 128'hBB);
    cyc(0, '0, '0, 1, 0);
    chk("skid_drain", 128'(o_valid), 128'(0));

    // flush in skid with a new entry offered
    cyc(1, 'h11, 5'h09, 1, 0);
    cyc(1, 'h22, 5'h0A, 0, 0);
    cyc(1, 'hCC, 5'h0B, 0, 1);
    chk("flush_valid", 128'(o_valid), 128'(0));
    chk("flush_ctrl", 128'(o_ctrl), 128'(0));
    chk("flush_rdy", 128'(o_ready), 128'(1));
    repeat (2) cyc(0, '0, '0, 1, 0);

    // bubble clears control bits
    cyc(1, 'h55, all1, 1, 0);
    chk("bub_regw", 128'(o_ctrl[CTRL_REGWRITE]), 128'(1));
    cyc(0, '0, '0, 1, 0);
    chk("bub_ctrl", 128'(o_ctrl), 128'(0));

`ifdef PIPE_STALL_CNT_EN
    // long stall saturates the counter; flush keeps it
    cyc(1, 'h77, 5'h01, 0, 0);
    repeat (20) cyc(0, '0, '0, 0, 0);
    chk("cnt_sat", 128'(o_stall_cnt), 128'd15);
    cyc(0, '0, '0, 0, 1);
    chk("cnt_flush", 128'(o_stall_cnt), 128'd15);
`endif

    // asynchronous reset while in skid
    cyc(1, 'hA1, 5'h11, 1, 0);
    cyc(1, 'hA2, 5'h12, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    reset_checks("async");
    qd.delete();
    qc.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      cyc(1'($urandom_range(0, 3) != 0),
          rd,
          CTRL_W'($urandom),
          1'($urandom_range(0, 9) < 6),
          1'($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Parametrised pipeline-stage register that replaces the fixed per-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries a data payload and a separate control-bit field.
- Adds a valid/ready handshake with a 2-entry skid so stalls do not create combinational ready paths.
- Adds a synchronous flush that inserts a bubble for branch/hazard recovery.
- Sits between every pair of adjacent MIPS pipeline stages.

Parameters:
DATA_W, 101, payload width in bits (EX/MEM default: alu_result 32 + read_rb_2 32 + branch_address 32 + write_address 5).
CTRL_W, 5, control-bit width (EX/MEM default: zf, branch, memWrite, regWrite, memToReg).
CNT_W, 16, stall-counter width; used only with PIPE_STALL_CNT_EN.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
i_valid  input  1  upstream stage presents a valid entry
o_ready  output  1  buffer can accept an entry this cycle
i_data  input  DATA_W  upstream payload
i_ctrl  input  CTRL_W  upstream control bits
i_flush  input  1  synchronous flush: discard all held entries
o_valid  output  1  o_data/o_ctrl hold a valid entry
i_ready  input  1  downstream stage accepts the entry this cycle
o_data  output  DATA_W  payload to downstream
o_ctrl  output  CTRL_W  control bits to downstream; all zero whenever o_valid=0
o_stall_cnt  output  CNT_W  stall-cycle count; present only with PIPE_STALL_CNT_EN

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state EMPTY, o_valid=0, o_ready=1, o_data=0, o_ctrl=0, skid registers=0, o_stall_cnt=0.
- Storage: a main register drives the outputs; a skid register is written only when downstream stalls.
- Upstream handshake: an entry is accepted when i_valid & o_ready.
- Downstream handshake: an entry is consumed when o_valid & i_ready.
- Latency: 1 cycle from acceptance to o_valid. Throughput: 1 entry/cycle while i_ready=1.
- o_valid = (state != EMPTY). o_ready = (state != SKID).
  - Both decode directly from the state flop; there is no combinational path from i_ready or i_valid to o_ready.
- State EMPTY:
  - i_valid=1: load main register, go to FULL.
  - Otherwise stay EMPTY.
- State FULL (i_ready / i_valid):
  - 1/1: load main with the new entry, stay FULL.
  - 1/0: go to EMPTY and clear main ctrl to 0.
  - 0/1: load skid register, go to SKID.
  - 0/0: hold.
- State SKID:
  - Upstream is not accepted; o_ready=0.
  - i_ready=1: move skid to main, go to FULL.
  - i_ready=0: hold all registers.
- Flush (i_flush=1 at a clock edge):
  - Highest priority, overrides any capture.
  - Next state is EMPTY. Main and skid ctrl are cleared to 0. Data registers hold their value (don't care).
  - An i_valid entry presented in the same cycle is dropped.
- Reset mid-operation: returns to reset values immediately; no entry survives.
- Entries are never reordered, duplicated or lost except by flush or reset.

Optional Feature:
Macro PIPE_STALL_CNT_EN.
- Defined: o_stall_cnt exists.
  - Increments by 1 each cycle with o_valid=1 & i_ready=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared by reset only; flush does not clear it.
- Undefined: no o_stall_cnt port and no counter logic.
  - Handshake and datapath behaviour are identical in both builds.

Decomposition:
- Package pipe_pkg holds:
  - State enum {EMPTY, FULL, SKID}.
  - EX/MEM control-bit indices: CTRL_ZF=0, CTRL_BRANCH=1, CTRL_MEMWRITE=2, CTRL_REGWRITE=3, CTRL_MEMTOREG=4.
  - Per-stage default DATA_W/CTRL_W constants.
- Sub-module pipe_sat_counter (width-parametrised saturating counter) implements o_stall_cnt; it is instantiated only under PIPE_STALL_CNT_EN.

Test Plan:
1. Reset with rst_n=0 mid-stream (state SKID) -> o_valid=0, o_ready=1, o_ctrl=0, o_data=0 immediately, without waiting for a clock edge.
2. Streaming: i_ready=1 held; i_data=0x10,0x20,0x30 on consecutive cycles -> o_data shows 0x10,0x20,0x30 one cycle later each, o_valid=1 throughout, o_ready stays 1.
3. Stall/skid: in FULL holding A=0xAA, set i_ready=0 and present B=0xBB -> state SKID, o_ready=0, o_data=0xAA. Release i_ready -> o_data=0xAA consumed, next cycle o_data=0xBB. No loss, no duplicate.
4. Flush in SKID while i_valid=1 with C=0xCC -> next cycle o_valid=0, o_ctrl=0, o_ready=1. Neither C nor the skid entry ever appears on the output.
5. Bubble: i_ctrl=5'b11111 accepted, then i_valid=0 with i_ready=1 -> after drain o_valid=0 and o_ctrl=5'b00000.
6. With PIPE_STALL_CNT_EN and CNT_W=4: hold o_valid=1, i_ready=0 for 20 cycles -> o_stall_cnt saturates at 15. A following flush leaves it at 15.
